// File: rtl/battle_pkg.sv
// battle_pkg
//   Shared types and constants for the battle controller: FSM state enum,
//   USB keycodes, default HP/damage/delay values, LFSR seed, and a
//   saturating-subtract helper used for every HP update.
package battle_pkg;

   typedef enum logic [3:0] {
      IDLE, INIT, MENU, P_ATK, P_WAIT, E_ATK, E_WAIT, DONE, EXIT
   } state_e;

   localparam logic [7:0] KEY_A     = 8'h04;
   localparam logic [7:0] KEY_D     = 8'h07;
   localparam logic [7:0] KEY_ENTER = 8'h28;
   localparam logic [7:0] KEY_W     = 8'h1A;

   localparam logic [7:0] DEF_MAX_HP       = 8'd100;
   localparam logic [7:0] DEF_MOVE0_DMG    = 8'd15;
   localparam logic [7:0] DEF_MOVE1_DMG    = 8'd30;
   localparam logic [7:0] DEF_ENEMY_DMG    = 8'd12;
   localparam logic [5:0] DEF_DELAY_FRAMES = 6'd30;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   // HP never wraps: anything at or below zero lands on zero.
   function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] b);
      return (a > b) ? (a - b) : 8'd0;
   endfunction

endpackage

// File: rtl/battle_control_lfsr16.sv
// lfsr16
//   Free-running 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1,
//   shifting right one step per clock. Used for move-1 miss rolls and
//   enemy sprite selection.
//   Ports: clk, rst_n (async, active low) -> lfsr (current register value).
module lfsr16
   import battle_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   output logic [15:0] lfsr
);

   logic [15:0] lfsr_q, lfsr_d;

   always_comb begin
      // Bit 0 falls out the bottom and is fed back into the tap positions.
      lfsr_d = {lfsr_q[0],
                lfsr_q[15],
                lfsr_q[14] ^ lfsr_q[0],
                lfsr_q[13] ^ lfsr_q[0],
                lfsr_q[12],
                lfsr_q[11] ^ lfsr_q[0],
                lfsr_q[10:1]};
      // Unreachable from a non-zero seed; guards against an upset.
      if (lfsr_q == 16'h0000) lfsr_d = LFSR_SEED;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) lfsr_q <= LFSR_SEED;
      else        lfsr_q <= lfsr_d;
   end

   assign lfsr = lfsr_q;

endmodule

// File: rtl/battle_control.sv
// battle_control
//   Turn-based battle FSM: three player pokemon vs three enemies. The player
//   picks a move in MENU, attacks, waits an animation delay, the enemy
//   counter-attacks, waits again, and so on until one side is wiped out.
//   Ports:
//     Clk, Reset (async, active low)
//     is_battle   - battle game state active
//     keycode     - held USB keycode, 0 = none
//     my_team     - player team sprite ids (not used by the battle rules)
//     frame_tick  - one pulse per video frame, paces the animation delays
//     my_cur, enemy_cur_id, my_hp_cur, enemy_hp_cur, move_sel - display state
//     end_battle  - single-cycle pulse at battle end, result = 1 on win
module battle_control
   import battle_pkg::*;
#(
   parameter logic [7:0] MAX_HP       = DEF_MAX_HP,
   parameter logic [7:0] MOVE0_DMG    = DEF_MOVE0_DMG,
   parameter logic [7:0] MOVE1_DMG    = DEF_MOVE1_DMG,
   parameter logic [7:0] ENEMY_DMG    = DEF_ENEMY_DMG,
   parameter logic [5:0] DELAY_FRAMES = DEF_DELAY_FRAMES
)(
   input  logic       Clk,
   input  logic       Reset,
   input  logic       is_battle,
   input  logic [7:0] keycode,
   input  logic [8:0] my_team,
   input  logic       frame_tick,
   output logic [1:0] my_cur,
   output logic [2:0] enemy_cur_id,
   output logic [7:0] my_hp_cur,
   output logic [7:0] enemy_hp_cur,
   output logic       move_sel,
   output logic       end_battle,
   output logic       result
);

   logic [15:0] lfsr;

   lfsr16 u_lfsr (
      .clk   (Clk),
      .rst_n (Reset),
      .lfsr  (lfsr)
   );

   state_e          state_q, state_d;
   logic [1:0]      my_cur_q, my_cur_d;
   logic [1:0]      en_idx_q, en_idx_d;
   logic            move_sel_q, move_sel_d;
   logic [2:0][7:0] my_hp_q, my_hp_d;
   logic [2:0][7:0] en_hp_q, en_hp_d;
   logic [2:0][2:0] en_id_q, en_id_d;
   logic            end_battle_q, end_battle_d;
   logic            result_q, result_d;
   logic [5:0]      cnt_q, cnt_d;
   logic [7:0]      prev_key_q, prev_key_d;

   logic       key_ev;
   logic       wait_done;
   logic [7:0] my_hp_act, en_hp_act, p_dmg;

   // Only a fresh non-zero keycode counts; a held key fires once.
   assign key_ev    = (keycode != 8'h00) && (keycode != prev_key_q);
   // Decision is taken the cycle after the last needed tick has been counted.
   assign wait_done = (cnt_q == DELAY_FRAMES);

   assign my_hp_act = (my_cur_q == 2'd2) ? my_hp_q[2] :
                      (my_cur_q == 2'd1) ? my_hp_q[1] : my_hp_q[0];
   assign en_hp_act = (en_idx_q == 2'd2) ? en_hp_q[2] :
                      (en_idx_q == 2'd1) ? en_hp_q[1] : en_hp_q[0];

   // Move 1 whiffs when the LFSR LSB is set during the attack cycle.
   assign p_dmg = move_sel_q ? (lfsr[0] ? 8'd0 : MOVE1_DMG) : MOVE0_DMG;

   always_comb begin
      state_d      = state_q;
      my_cur_d     = my_cur_q;
      en_idx_d     = en_idx_q;
      move_sel_d   = move_sel_q;
      my_hp_d      = my_hp_q;
      en_hp_d      = en_hp_q;
      en_id_d      = en_id_q;
      end_battle_d = 1'b0;
      result_d     = result_q;
      cnt_d        = cnt_q;
      prev_key_d   = keycode;

      unique case (state_q)
         IDLE: if (is_battle) state_d = INIT;
         INIT: begin
            my_hp_d    = {3{MAX_HP}};
            en_hp_d    = {3{MAX_HP}};
            my_cur_d   = 2'd0;
            en_idx_d   = 2'd0;
            move_sel_d = 1'b0;
            result_d   = 1'b0;
            en_id_d    = {lfsr[8:6], lfsr[5:3], lfsr[2:0]};
            state_d    = MENU;
         end
         MENU: begin
            if (key_ev) begin
               if (keycode == KEY_A || keycode == KEY_D) move_sel_d = ~move_sel_q;
               else if (keycode == KEY_ENTER)            state_d    = P_ATK;
            end
         end
         P_ATK: begin
            for (int i = 0; i < 3; i++)
               if (en_idx_q == i[1:0]) en_hp_d[i] = sat_sub(en_hp_act, p_dmg);
            cnt_d   = 6'd0;
            state_d = P_WAIT;
         end
         P_WAIT: begin
            if (wait_done) begin
               if (en_hp_act != 8'd0) begin
                  state_d = E_ATK;
               end else if (en_idx_q == 2'd2) begin
                  state_d      = DONE;
                  result_d     = 1'b1;
                  end_battle_d = 1'b1;
               end else begin
                  en_idx_d = en_idx_q + 2'd1;
                  state_d  = MENU;
               end
            end else if (frame_tick) begin
               cnt_d = cnt_q + 6'd1;
            end
         end
         E_ATK: begin
            for (int i = 0; i < 3; i++)
               if (my_cur_q == i[1:0]) my_hp_d[i] = sat_sub(my_hp_act, ENEMY_DMG);
            cnt_d   = 6'd0;
            state_d = E_WAIT;
         end
         E_WAIT: begin
            if (wait_done) begin
               if (my_hp_act != 8'd0) begin
                  state_d = MENU;
               end else if (my_cur_q == 2'd2) begin
                  state_d      = DONE;
                  result_d     = 1'b0;
                  end_battle_d = 1'b1;
               end else begin
                  my_cur_d = my_cur_q + 2'd1;
                  state_d  = MENU;
               end
            end else if (frame_tick) begin
               cnt_d = cnt_q + 6'd1;
            end
         end
         DONE: state_d = EXIT;
         EXIT: if (!is_battle) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Leaving the battle screen mid-fight aborts silently.
      if (!is_battle && state_q != IDLE && state_q != EXIT) begin
         state_d      = IDLE;
         end_battle_d = 1'b0;
         result_d     = result_q;
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q      <= IDLE;
         my_cur_q     <= 2'd0;
         en_idx_q     <= 2'd0;
         move_sel_q   <= 1'b0;
         my_hp_q      <= '0;
         en_hp_q      <= '0;
         en_id_q      <= '0;
         end_battle_q <= 1'b0;
         result_q     <= 1'b0;
         cnt_q        <= 6'd0;
         prev_key_q   <= 8'h00;
      end else begin
         state_q      <= state_d;
         my_cur_q     <= my_cur_d;
         en_idx_q     <= en_idx_d;
         move_sel_q   <= move_sel_d;
         my_hp_q      <= my_hp_d;
         en_hp_q      <= en_hp_d;
         en_id_q      <= en_id_d;
         end_battle_q <= end_battle_d;
         result_q     <= result_d;
         cnt_q        <= cnt_d;
         prev_key_q   <= prev_key_d;
      end
   end

   assign my_cur       = my_cur_q;
   assign move_sel     = move_sel_q;
   assign end_battle   = end_battle_q;
   assign result       = result_q;
   assign my_hp_cur    = my_hp_act;
   assign enemy_hp_cur = en_hp_act;
   assign enemy_cur_id = (en_idx_q == 2'd2) ? en_id_q[2] :
                         (en_idx_q == 2'd1) ? en_id_q[1] : en_id_q[0];

   // Team ids and upper LFSR bits feed other blocks, not the battle rules.
   logic unused_bits;
   assign unused_bits = ^{my_team, lfsr[15:9]};

endmodule

// File: tb/tb_battle_control.sv
module tb_battle_control;

   localparam logic [7:0] K_A = 8'h04, K_D = 8'h07, K_ENTER = 8'h28, K_W = 8'h1A;

   logic       Clk, Reset, is_battle, frame_tick;
   logic [7:0] keycode;
   logic [8:0] my_team;

   logic [1:0] o_cur [3];
   logic [2:0] o_id  [3];
   logic [7:0] o_mhp [3];
   logic [7:0] o_ehp [3];
   logic       o_sel [3];
   logic       o_end [3];
   logic       o_res [3];

   // Three configurations share one stimulus stream.
   battle_control #(.DELAY_FRAMES(6'd2)) u_a (
      .Clk(Clk), .Reset(Reset), .is_battle(is_battle), .keycode(keycode),
      .my_team(my_team), .frame_tick(frame_tick), .my_cur(o_cur[0]),
      .enemy_cur_id(o_id[0]), .my_hp_cur(o_mhp[0]), .enemy_hp_cur(o_ehp[0]),
      .move_sel(o_sel[0]), .end_battle(o_end[0]), .result(o_res[0]));

   battle_control #(.MAX_HP(8'd15), .DELAY_FRAMES(6'd2)) u_b (
      .Clk(Clk), .Reset(Reset), .is_battle(is_battle), .keycode(keycode),
      .my_team(my_team), .frame_tick(frame_tick), .my_cur(o_cur[1]),
      .enemy_cur_id(o_id[1]), .my_hp_cur(o_mhp[1]), .enemy_hp_cur(o_ehp[1]),
      .move_sel(o_sel[1]), .end_battle(o_end[1]), .result(o_res[1]));

   battle_control #(.MOVE0_DMG(8'd1), .ENEMY_DMG(8'd100), .DELAY_FRAMES(6'd2)) u_c (
      .Clk(Clk), .Reset(Reset), .is_battle(is_battle), .keycode(keycode),
      .my_team(my_team), .frame_tick(frame_tick), .my_cur(o_cur[2]),
      .enemy_cur_id(o_id[2]), .my_hp_cur(o_mhp[2]), .enemy_hp_cur(o_ehp[2]),
      .move_sel(o_sel[2]), .end_battle(o_end[2]), .result(o_res[2]));

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int checks = 0;
   int fails  = 0;

   // Reference: configuration per instance and battle state per instance.
   int p_max [3] = '{100, 15, 100};
   int p_m0  [3] = '{15, 15, 1};
   int p_m1  [3] = '{30, 30, 30};
   int p_ed  [3] = '{12, 12, 100};

   int mh [3][3];
   int eh [3][3];
   int ids[3][3];
   int mc [3];
   int ei [3];
   int sel[3];
   int act[3];
   int res[3];
   int pend[3];
   int exp_end[3] = '{0, 0, 0};

   // Reference random source: the polynomial as a shift-and-xor mask.
   logic [15:0] m_lfsr;
   always @(posedge Clk or negedge Reset) begin
      if (!Reset) m_lfsr <= 16'hACE1;
      else        m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
   end

   int end_cnt[3] = '{0, 0, 0};
   always @(posedge Clk) begin
      for (int d = 0; d < 3; d++)
         if (o_end[d] === 1'b1) end_cnt[d] <= end_cnt[d] + 1;
   end

   task automatic step();
      @(negedge Clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int sat(input int a, input int b);
      return (a > b) ? a - b : 0;
   endfunction

   task automatic model_init(input logic [15:0] l);
      for (int d = 0; d < 3; d++) begin
         for (int k = 0; k < 3; k++) begin
            mh[d][k] = p_max[d];
            eh[d][k] = p_max[d];
         end
         ids[d][0] = int'(l[2:0]);
         ids[d][1] = int'(l[5:3]);
         ids[d][2] = int'(l[8:6]);
         mc[d] = 0; ei[d] = 0; sel[d] = 0; act[d] = 1; res[d] = 0; pend[d] = 0;
      end
   endtask

   // Player strike and, if the enemy survives, its counter-strike.
   task automatic model_p(input bit miss);
      int dmg;
      for (int d = 0; d < 3; d++) begin
         if (act[d] == 0) continue;
         dmg = (sel[d] != 0) ? (miss ? 0 : p_m1[d]) : p_m0[d];
         eh[d][ei[d]] = sat(eh[d][ei[d]], dmg);
         if (eh[d][ei[d]] == 0) begin
            if (ei[d] == 2) begin act[d] = 0; res[d] = 1; exp_end[d]++; end
            else ei[d]++;
         end else begin
            mh[d][mc[d]] = sat(mh[d][mc[d]], p_ed[d]);
            pend[d] = 1;
         end
      end
   endtask

   // Resolution after the enemy's animation: faint -> swap or lose.
   task automatic model_e();
      for (int d = 0; d < 3; d++) begin
         if (pend[d] == 0) continue;
         pend[d] = 0;
         if (mh[d][mc[d]] == 0) begin
            if (mc[d] == 2) begin act[d] = 0; res[d] = 0; exp_end[d]++; end
            else mc[d]++;
         end
      end
   endtask

   task automatic check_all(input string tag);
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("%s_d%0d_cur", tag, d), o_cur[d], mc[d]);
         chk($sformatf("%s_d%0d_myhp", tag, d), o_mhp[d], mh[d][mc[d]]);
         chk($sformatf("%s_d%0d_enhp", tag, d), o_ehp[d], eh[d][ei[d]]);
         chk($sformatf("%s_d%0d_enid", tag, d), o_id[d], ids[d][ei[d]]);
         chk($sformatf("%s_d%0d_sel", tag, d), o_sel[d], sel[d]);
         chk($sformatf("%s_d%0d_res", tag, d), o_res[d], res[d]);
         chk($sformatf("%s_d%0d_ends", tag, d), end_cnt[d], exp_end[d]);
      end
   endtask

   task automatic press(input logic [7:0] k);
      keycode = k; step;
      keycode = 8'h00; step;
      if (k == K_A || k == K_D)
         for (int d = 0; d < 3; d++) if (act[d] != 0) sel[d] ^= 1;
   endtask

   task automatic do_turn(input bit hold, input bit mid_zero, input string tag);
      bit miss;
      keycode = K_ENTER; step;
      miss = m_lfsr[0];
      if (!hold) keycode = 8'h00;
      step;
      frame_tick = 1'b1; step; step; frame_tick = 1'b0;
      repeat (4) step;
      model_p(miss);
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("%s_mid_d%0d_cur", tag, d), o_cur[d], mc[d]);
         chk($sformatf("%s_mid_d%0d_myhp", tag, d), o_mhp[d], mh[d][mc[d]]);
      end
      if (mid_zero) chk("hp_saturates_zero", o_mhp[0], 0);
      frame_tick = 1'b1; step; step; frame_tick = 1'b0;
      step; step;
      model_e();
      if (hold) begin
         repeat (38) step;
         keycode = 8'h00; step;
      end
      check_all(tag);
   endtask

   task automatic start_battle(input string tag);
      is_battle = 1'b1; step;
      model_init(m_lfsr);
      step;
      check_all(tag);
   endtask

   initial begin
      int base;
      Reset = 1'b0; is_battle = 1'b0; keycode = 8'h00; frame_tick = 1'b0;
      my_team = 9'($urandom);
      repeat (3) step;
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("rst_d%0d_cur", d), o_cur[d], 0);
         chk($sformatf("rst_d%0d_myhp", d), o_mhp[d], 0);
         chk($sformatf("rst_d%0d_enhp", d), o_ehp[d], 0);
         chk($sformatf("rst_d%0d_sel", d), o_sel[d], 0);
         chk($sformatf("rst_d%0d_end", d), o_end[d], 0);
         chk($sformatf("rst_d%0d_res", d), o_res[d], 0);
      end
      Reset = 1'b1; step;
      start_battle("init");

      // Seven move-0 turns; B wins and C loses along the way.
      for (int t = 1; t <= 7; t++) begin
         do_turn(1'b0, 1'b0, $sformatf("dir%0d", t));
         if (t == 6) chk("a_enhp_after6", o_ehp[0], 10);
         if (t == 3) begin
            chk("b_end_once", end_cnt[1], 1);
            chk("b_result_win", o_res[1], 1);
            chk("b_myhp", o_mhp[1], 15);
            chk("b_mycur", o_cur[1], 0);
            chk("c_end_once", end_cnt[2], 1);
            chk("c_result_lose", o_res[2], 0);
            chk("c_mycur", o_cur[2], 2);
         end
         if (t == 7) begin
            chk("a_enhp_after7", o_ehp[0], 100);
            chk("a_myhp_after7", o_mhp[0], 28);
         end
      end
      do_turn(1'b0, 1'b0, "dir8");
      do_turn(1'b0, 1'b0, "dir9");
      chk("a_myhp_4", o_mhp[0], 4);
      do_turn(1'b0, 1'b1, "dir10");
      chk("a_swap_after_faint", o_cur[0], 1);

      press(K_A); press(K_D); press(K_A);
      chk("ada_move_sel", o_sel[0], 1);
      do_turn(1'b1, 1'b0, "held_enter");

      // Drop out of the battle screen during the player's wait.
      base = end_cnt[0];
      keycode = K_ENTER; step;
      keycode = 8'h00; step;
      is_battle = 1'b0; step;
      chk("abort_no_end", o_end[0], 0);
      repeat (3) step;
      chk("abort_end_cnt", end_cnt[0], base);
      start_battle("reinit");
      chk("reinit_hp", o_mhp[0], 100);

      for (int r = 0; r < 15; r++) begin
         int n;
         n = $urandom_range(0, 3);
         for (int i = 0; i < n; i++) press(($urandom_range(0, 1) != 0) ? K_D : K_A);
         if ($urandom_range(0, 3) == 0) press(K_W);
         repeat ($urandom_range(0, 4)) step;
         do_turn(1'b0, 1'b0, $sformatf("rnd%0d", r));
      end

      // Reset asserted mid-battle.
      is_battle = 1'b0; step; step;
      start_battle("pre_reset");
      for (int d = 0; d < 3; d++) base = base + 0;
      keycode = K_ENTER; step;
      keycode = 8'h00; step;
      Reset = 1'b0; step;
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("midrst_d%0d_myhp", d), o_mhp[d], 0);
         chk($sformatf("midrst_d%0d_enhp", d), o_ehp[d], 0);
         chk($sformatf("midrst_d%0d_end", d), o_end[d], 0);
         chk($sformatf("midrst_d%0d_ends", d), end_cnt[d], exp_end[d]);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
